// File: rtl/renkon_conv_seq.sv
// ---------------------------------------------------------------------------
// renkon_conv_seq
//
// Convolution-layer sequencer. On a start request it latches the layer
// configuration and walks the loop nest (output-channel group, output row,
// output column, input channel, kernel row, kernel column). It issues one
// image/weight read per cycle to an NCORE-wide conv datapath.
//
// Ports
//   clk          clock
//   xrst         synchronous active-high reset
//   req          start pulse, sampled only while idle
//   stall        downstream not ready; freezes the sequence
//   in_offset    image base address
//   net_offset   weight base address
//   total_in     input channel count
//   total_out    output channel count
//   img_size     input image side length
//   conv_size    kernel side length
//   stride       convolution stride
//   ack          idle and ready for req
//   done         one-cycle pulse at end of layer (also after a config error)
//   err          configuration error, held until the next accepted req
//   rd_valid     img_addr/net_addr carry a read this cycle
//   img_addr     image read address
//   net_addr     weight read address
//   first_input  first product of an output pixel
//   last_input   last product of an output pixel
//   core_mask    bit c set when core c is active in the current group
//   fea_size     output feature side length, latched during setup
// ---------------------------------------------------------------------------
module renkon_conv_seq #(
   parameter int NCORE   = 8,
   parameter int LWIDTH  = 12,
   parameter int IMGSIZE = 16,
   parameter int NETSIZE = 14
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               req,
   input  logic               stall,
   input  logic [IMGSIZE-1:0] in_offset,
   input  logic [NETSIZE-1:0] net_offset,
   input  logic [LWIDTH-1:0]  total_in,
   input  logic [LWIDTH-1:0]  total_out,
   input  logic [LWIDTH-1:0]  img_size,
   input  logic [LWIDTH-1:0]  conv_size,
   input  logic [LWIDTH-1:0]  stride,
   output logic               ack,
   output logic               done,
   output logic               err,
   output logic               rd_valid,
   output logic [IMGSIZE-1:0] img_addr,
   output logic [NETSIZE-1:0] net_addr,
   output logic               first_input,
   output logic               last_input,
   output logic [NCORE-1:0]   core_mask,
   output logic [LWIDTH-1:0]  fea_size
);

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

   localparam logic [LWIDTH-1:0] ONE = LWIDTH'(1);

   state_t state, state_next;

   // latched layer configuration
   logic [IMGSIZE-1:0] in_off_r;
   logic [NETSIZE-1:0] net_off_r;
   logic [LWIDTH-1:0]  tin_r, tout_r, img_r, conv_r, stride_r;
   logic [LWIDTH-1:0]  ngrp_r;

   // loop counters
   logic [LWIDTH-1:0]  g, oy, ox, ic, ky, kx;

   // running address terms; each holds its counter times the matching step
   logic [IMGSIZE-1:0] row_off, col_off, ch_off, ky_off;
   logic [NETSIZE-1:0] grp_w, ch_w, ky_w;
   logic [31:0]        g_chan;

   // per-layer address steps, computed once in setup
   logic [IMGSIZE-1:0] img_sq, stride_img, stride_i, img_n;
   logic [NETSIZE-1:0] conv_sq, tin_csq, conv_n;

   // set once the final beat has been registered; gives the drain cycle
   logic               run_end;

   logic               cfg_err;
   logic [LWIDTH-1:0]  stride_safe;
   logic [LWIDTH-1:0]  fea_calc;
   logic [LWIDTH-1:0]  ngrp_calc;
   logic               kx_last, ky_last, ic_last, ox_last, oy_last, g_last;
   logic               all_last;
   logic               beat;
   logic [NCORE-1:0]   mask_calc;

   // Configuration checks and derived sizes from the latched fields.
   // The divisor is forced non-zero so an illegal stride never reaches the
   // divider; the result is only used when cfg_err is clear.
   always_comb begin
      cfg_err     = (tin_r == '0) || (tout_r == '0) || (stride_r == '0) ||
                    (conv_r == '0) || (conv_r > img_r);
      stride_safe = (stride_r == '0) ? ONE : stride_r;
      fea_calc    = (img_r - conv_r) / stride_safe + ONE;
      ngrp_calc   = LWIDTH'((32'(tout_r) + 32'(NCORE) - 32'd1) / 32'(NCORE));
   end

   // Wrap conditions for each loop level and the beat-issue condition.
   always_comb begin
      kx_last  = (kx == conv_r - ONE);
      ky_last  = (ky == conv_r - ONE);
      ic_last  = (ic == tin_r - ONE);
      ox_last  = (ox == fea_size - ONE);
      oy_last  = (oy == fea_size - ONE);
      g_last   = (g == ngrp_r - ONE);
      all_last = kx_last && ky_last && ic_last && ox_last && oy_last && g_last;
      beat     = (state == RUN) && !stall && !run_end;
   end

   // Core enable mask for the current group: a core is active while its
   // output channel index is still below total_out.
   always_comb begin
      mask_calc = '0;
      for (int c = 0; c < NCORE; c++) begin
         mask_calc[c] = ((g_chan + 32'(c)) < 32'(tout_r));
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (xrst) state <= IDLE;
      else      state <= state_next;
   end

   // FSM next-state logic. RUN lingers for one drain cycle after the last
   // beat so that done follows the final read instead of overlapping it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req) state_next = SETUP;
         SETUP:   state_next = cfg_err ? DONE : RUN;
         RUN:     if (run_end) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      ack  = (state == IDLE);
      done = (state == DONE);
   end

   // Datapath: config latch, setup products, loop counters with ripple
   // carry, and the registered read outputs. On a stalled cycle nothing
   // but rd_valid changes, so addresses and flags hold their last beat.
   always_ff @(posedge clk) begin
      if (xrst) begin
         err         <= 1'b0;
         rd_valid    <= 1'b0;
         img_addr    <= '0;
         net_addr    <= '0;
         first_input <= 1'b0;
         last_input  <= 1'b0;
         core_mask   <= '0;
         fea_size    <= '0;
         in_off_r    <= '0;
         net_off_r   <= '0;
         tin_r       <= '0;
         tout_r      <= '0;
         img_r       <= '0;
         conv_r      <= '0;
         stride_r    <= '0;
         ngrp_r      <= '0;
         g           <= '0;
         oy          <= '0;
         ox          <= '0;
         ic          <= '0;
         ky          <= '0;
         kx          <= '0;
         row_off     <= '0;
         col_off     <= '0;
         ch_off      <= '0;
         ky_off      <= '0;
         grp_w       <= '0;
         ch_w        <= '0;
         ky_w        <= '0;
         g_chan      <= '0;
         img_sq      <= '0;
         stride_img  <= '0;
         stride_i    <= '0;
         img_n       <= '0;
         conv_sq     <= '0;
         tin_csq     <= '0;
         conv_n      <= '0;
         run_end     <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  in_off_r  <= in_offset;
                  net_off_r <= net_offset;
                  tin_r     <= total_in;
                  tout_r    <= total_out;
                  img_r     <= img_size;
                  conv_r    <= conv_size;
                  stride_r  <= stride;
                  err       <= 1'b0;
               end
            end

            SETUP: begin
               run_end <= 1'b0;
               g       <= '0;
               oy      <= '0;
               ox      <= '0;
               ic      <= '0;
               ky      <= '0;
               kx      <= '0;
               row_off <= '0;
               col_off <= '0;
               ch_off  <= '0;
               ky_off  <= '0;
               grp_w   <= '0;
               ch_w    <= '0;
               ky_w    <= '0;
               g_chan  <= '0;
               if (cfg_err) begin
                  err      <= 1'b1;
                  fea_size <= '0;
               end else begin
                  fea_size   <= fea_calc;
                  ngrp_r     <= ngrp_calc;
                  img_sq     <= IMGSIZE'(32'(img_r) * 32'(img_r));
                  stride_img <= IMGSIZE'(32'(stride_r) * 32'(img_r));
                  stride_i   <= IMGSIZE'(stride_r);
                  img_n      <= IMGSIZE'(img_r);
                  conv_sq    <= NETSIZE'(32'(conv_r) * 32'(conv_r));
                  tin_csq    <= NETSIZE'(32'(tin_r) * 32'(conv_r) * 32'(conv_r));
                  conv_n     <= NETSIZE'(conv_r);
               end
            end

            RUN: begin
               if (beat) begin
                  rd_valid    <= 1'b1;
                  img_addr    <= in_off_r + row_off + col_off + ch_off + ky_off
                                 + IMGSIZE'(kx);
                  net_addr    <= net_off_r + grp_w + ch_w + ky_w + NETSIZE'(kx);
                  first_input <= (ic == '0) && (ky == '0) && (kx == '0);
                  last_input  <= ic_last && ky_last && kx_last;
                  core_mask   <= mask_calc;

                  if (all_last) run_end <= 1'b1;

                  if (!kx_last) begin
                     kx <= kx + ONE;
                  end else begin
                     kx <= '0;
                     if (!ky_last) begin
                        ky     <= ky + ONE;
                        ky_off <= ky_off + img_n;
                        ky_w   <= ky_w + conv_n;
                     end else begin
                        ky     <= '0;
                        ky_off <= '0;
                        ky_w   <= '0;
                        if (!ic_last) begin
                           ic     <= ic + ONE;
                           ch_off <= ch_off + img_sq;
                           ch_w   <= ch_w + conv_sq;
                        end else begin
                           ic     <= '0;
                           ch_off <= '0;
                           ch_w   <= '0;
                           if (!ox_last) begin
                              ox      <= ox + ONE;
                              col_off <= col_off + stride_i;
                           end else begin
                              ox      <= '0;
                              col_off <= '0;
                              if (!oy_last) begin
                                 oy      <= oy + ONE;
                                 row_off <= row_off + stride_img;
                              end else begin
                                 oy      <= '0;
                                 row_off <= '0;
                                 if (!g_last) begin
                                    g      <= g + ONE;
                                    grp_w  <= grp_w + tin_csq;
                                    g_chan <= g_chan + 32'(NCORE);
                                 end
                              end
                           end
                        end
                     end
                  end
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_renkon_conv_seq.sv
// ---------------------------------------------------------------------------
// tb_renkon_conv_seq
//
// Scoreboard bench for renkon_conv_seq. Each layer start pushes the expected
// read beats (computed from the closed-form address formulas) into a queue;
// a monitor pops and compares whenever rd_valid is seen. Directed checks on
// hand-computed beats, stall freezing, config errors and reset are layered
// on top.
// ---------------------------------------------------------------------------
module tb_renkon_conv_seq;

   localparam int NCORE   = 8;
   localparam int LWIDTH  = 12;
   localparam int IMGSIZE = 16;
   localparam int NETSIZE = 14;

   logic               clk = 1'b0;
   logic               xrst, req, stall;
   logic [IMGSIZE-1:0] in_offset;
   logic [NETSIZE-1:0] net_offset;
   logic [LWIDTH-1:0]  total_in, total_out, img_size, conv_size, stride;
   logic               ack, done, err, rd_valid;
   logic [IMGSIZE-1:0] img_addr;
   logic [NETSIZE-1:0] net_addr;
   logic               first_input, last_input;
   logic [NCORE-1:0]   core_mask;
   logic [LWIDTH-1:0]  fea_size;

   typedef struct packed {
      logic [IMGSIZE-1:0] img;
      logic [NETSIZE-1:0] net;
      logic               first;
      logic               last;
      logic [NCORE-1:0]   mask;
   } beat_t;

   beat_t exp_q[$];
   beat_t act_log[$];
   beat_t mon_a, mon_e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int beat_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_beat_cyc = 0;
   int req_cyc = 0;

   renkon_conv_seq #(
      .NCORE(NCORE), .LWIDTH(LWIDTH), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE)
   ) dut (
      .clk(clk), .xrst(xrst), .req(req), .stall(stall),
      .in_offset(in_offset), .net_offset(net_offset),
      .total_in(total_in), .total_out(total_out), .img_size(img_size),
      .conv_size(conv_size), .stride(stride),
      .ack(ack), .done(done), .err(err), .rd_valid(rd_valid),
      .img_addr(img_addr), .net_addr(net_addr),
      .first_input(first_input), .last_input(last_input),
      .core_mask(core_mask), .fea_size(fea_size)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // Monitor: compare every presented beat against the scoreboard head and
   // record done pulses with their cycle number.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         mon_a.img   = img_addr;
         mon_a.net   = net_addr;
         mon_a.first = first_input;
         mon_a.last  = last_input;
         mon_a.mask  = core_mask;
         act_log.push_back(mon_a);
         beat_cnt++;
         last_beat_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got %0h expected none", mon_a);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("beat", 64'(mon_a), 64'(mon_e));
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // Reference model: push every beat of a layer using the direct formulas.
   task automatic pushExpected(input int tin, input int tout, input int img,
                               input int conv, input int strd, input int inoff,
                               input int netoff);
      int    fea, ngrp;
      beat_t b;
      fea  = (img - conv) / strd + 1;
      ngrp = (tout + NCORE - 1) / NCORE;
      for (int g = 0; g < ngrp; g++)
         for (int oy = 0; oy < fea; oy++)
            for (int ox = 0; ox < fea; ox++)
               for (int i = 0; i < tin; i++)
                  for (int ky = 0; ky < conv; ky++)
                     for (int kx = 0; kx < conv; kx++) begin
                        b.img   = IMGSIZE'(inoff + i * img * img
                                  + (oy * strd + ky) * img + ox * strd + kx);
                        b.net   = NETSIZE'(netoff + (g * tin + i) * conv * conv
                                  + ky * conv + kx);
                        b.first = (i == 0) && (ky == 0) && (kx == 0);
                        b.last  = (i == tin - 1) && (ky == conv - 1) && (kx == conv - 1);
                        for (int c = 0; c < NCORE; c++)
                           b.mask[c] = ((g * NCORE + c) < tout);
                        exp_q.push_back(b);
                     end
   endtask

   // Drive a layer configuration with a one-cycle req, then scramble the
   // config inputs to show they are only sampled at acceptance.
   task automatic applyStimulus(input int tin, input int tout, input int img,
                                input int conv, input int strd, input int inoff,
                                input int netoff);
      @(negedge clk);
      total_in   = LWIDTH'(tin);
      total_out  = LWIDTH'(tout);
      img_size   = LWIDTH'(img);
      conv_size  = LWIDTH'(conv);
      stride     = LWIDTH'(strd);
      in_offset  = IMGSIZE'(inoff);
      net_offset = NETSIZE'(netoff);
      req        = 1'b1;
      req_cyc    = cyc;
      @(negedge clk);
      req        = 1'b0;
      total_in   = 12'h7A5;
      total_out  = 12'h3C1;
      img_size   = 12'h011;
      conv_size  = 12'h002;
      stride     = 12'h003;
      in_offset  = 16'hBEEF;
      net_offset = 14'h1234;
   endtask

   task automatic waitDone(input int start_cnt, input string name);
      int n;
      n = 0;
      while (done_cnt == start_cnt && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done_cnt == start_cnt) begin
         errors++;
         $display("[TB] FAIL %s_timeout: got no done expected done", name);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int b0, base, d0, t2_len, n, nw, seen;
      logic [IMGSIZE-1:0] hold_img;
      logic [NETSIZE-1:0] hold_net;

      xrst = 1'b1; req = 1'b0; stall = 1'b0;
      in_offset = '0; net_offset = '0;
      total_in = '0; total_out = '0; img_size = '0; conv_size = '0; stride = '0;

      // reset then idle
      repeat (2) @(negedge clk);
      checkOutput("rst_ack", 64'(ack), 64'd1);
      checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_img_addr", 64'(img_addr), 64'd0);
      checkOutput("rst_net_addr", 64'(net_addr), 64'd0);
      checkOutput("rst_core_mask", 64'(core_mask), 64'd0);
      checkOutput("rst_fea_size", 64'(fea_size), 64'd0);
      xrst = 1'b0;

      // basic layer, no stall
      $display("[TB] basic layer");
      b0 = beat_cnt; base = act_log.size(); d0 = done_cnt;
      pushExpected(1, 8, 4, 3, 1, 0, 0);
      applyStimulus(1, 8, 4, 3, 1, 0, 0);
      waitDone(d0, "basic");
      t2_len = done_cyc - req_cyc;
      checkOutput("basic_beats", 64'(beat_cnt - b0), 64'd36);
      checkOutput("basic_queue_empty", 64'(exp_q.size()), 64'd0);
      checkOutput("basic_fea_size", 64'(fea_size), 64'd2);
      if (act_log.size() >= base + 10) begin
         checkOutput("basic_b0_img", 64'(act_log[base].img), 64'd0);
         checkOutput("basic_b0_net", 64'(act_log[base].net), 64'd0);
         checkOutput("basic_b0_first", 64'(act_log[base].first), 64'd1);
         checkOutput("basic_b0_mask", 64'(act_log[base].mask), 64'hFF);
         checkOutput("basic_b8_img", 64'(act_log[base+8].img), 64'd10);
         checkOutput("basic_b8_net", 64'(act_log[base+8].net), 64'd8);
         checkOutput("basic_b8_last", 64'(act_log[base+8].last), 64'd1);
         checkOutput("basic_b9_img", 64'(act_log[base+9].img), 64'd1);
      end
      checkOutput("basic_done_after_last", 64'(done_cyc - last_beat_cyc), 64'd1);
      @(negedge clk);
      checkOutput("basic_ack_after_done", 64'(ack), 64'd1);
      checkOutput("basic_err", 64'(err), 64'd0);

      // partial last group with stride 2
      $display("[TB] partial group and stride");
      b0 = beat_cnt; base = act_log.size(); d0 = done_cnt;
      pushExpected(2, 10, 5, 3, 2, 100, 18);
      applyStimulus(2, 10, 5, 3, 2, 100, 18);
      waitDone(d0, "stride");
      checkOutput("stride_beats", 64'(beat_cnt - b0), 64'd144);
      checkOutput("stride_queue_empty", 64'(exp_q.size()), 64'd0);
      checkOutput("stride_fea_size", 64'(fea_size), 64'd2);
      if (act_log.size() >= base + 73) begin
         checkOutput("stride_g0_mask", 64'(act_log[base].mask), 64'hFF);
         checkOutput("stride_ch1_img", 64'(act_log[base+9].img), 64'd125);
         checkOutput("stride_px01_img", 64'(act_log[base+18].img), 64'd102);
         checkOutput("stride_g1_mask", 64'(act_log[base+72].mask), 64'h03);
         checkOutput("stride_g1_net", 64'(act_log[base+72].net), 64'd36);
      end

      // stall in the middle of the basic layer
      $display("[TB] stall");
      b0 = beat_cnt; d0 = done_cnt;
      pushExpected(1, 8, 4, 3, 1, 0, 0);
      applyStimulus(1, 8, 4, 3, 1, 0, 0);
      n = 0; nw = 0;
      while (n < 3 && nw < 200) begin
         @(negedge clk);
         if (rd_valid === 1'b1) n++;
         nw++;
      end
      hold_img = img_addr;
      hold_net = net_addr;
      stall = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("stall_rd_valid", 64'(rd_valid), 64'd0);
         checkOutput("stall_img_hold", 64'(img_addr), 64'(hold_img));
         checkOutput("stall_net_hold", 64'(net_addr), 64'(hold_net));
      end
      stall = 1'b0;
      waitDone(d0, "stall");
      checkOutput("stall_beats", 64'(beat_cnt - b0), 64'd36);
      checkOutput("stall_queue_empty", 64'(exp_q.size()), 64'd0);
      checkOutput("stall_done_delay", 64'((done_cyc - req_cyc) - t2_len), 64'd4);

      // configuration errors: kernel larger than image, then zero stride
      $display("[TB] config errors");
      for (int k = 0; k < 2; k++) begin
         b0 = beat_cnt;
         if (k == 0) applyStimulus(1, 8, 4, 5, 1, 0, 0);
         else        applyStimulus(1, 8, 4, 3, 0, 0, 0);
         seen = 0;
         repeat (2) begin
            @(negedge clk);
            if (done === 1'b1 && err === 1'b1) seen = 1;
         end
         checkOutput("cfgerr_done_err", 64'(seen), 64'd1);
         checkOutput("cfgerr_no_beats", 64'(beat_cnt - b0), 64'd0);
         @(negedge clk);
         checkOutput("cfgerr_err_held", 64'(err), 64'd1);
         checkOutput("cfgerr_ack", 64'(ack), 64'd1);
      end

      // reset in the middle of a run
      $display("[TB] reset mid-run");
      pushExpected(1, 8, 4, 3, 1, 0, 0);
      applyStimulus(1, 8, 4, 3, 1, 0, 0);
      n = 0; nw = 0;
      while (n < 20 && nw < 200) begin
         @(negedge clk);
         if (rd_valid === 1'b1) n++;
         nw++;
      end
      checkOutput("midrun_err_cleared", 64'(err), 64'd0);
      d0 = done_cnt;
      xrst = 1'b1;
      @(negedge clk);
      checkOutput("midrun_ack", 64'(ack), 64'd1);
      checkOutput("midrun_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("midrun_done", 64'(done), 64'd0);
      checkOutput("midrun_img_addr", 64'(img_addr), 64'd0);
      xrst = 1'b0;
      exp_q.delete();
      repeat (5) @(negedge clk);
      checkOutput("midrun_no_done", 64'(done_cnt - d0), 64'd0);

      // req while running is ignored
      $display("[TB] ignored req");
      b0 = beat_cnt; d0 = done_cnt;
      pushExpected(1, 8, 4, 3, 1, 0, 0);
      applyStimulus(1, 8, 4, 3, 1, 0, 0);
      repeat (5) @(negedge clk);
      total_in  = 12'd2;
      conv_size = 12'd1;
      req       = 1'b1;
      @(negedge clk);
      req       = 1'b0;
      waitDone(d0, "ignreq");
      checkOutput("ignreq_beats", 64'(beat_cnt - b0), 64'd36);
      checkOutput("ignreq_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      checkOutput("ignreq_single_done", 64'(done_cnt - d0), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
